// File: rtl/dma_seq.sv
// Sequencer that programs an AM2940 DMA address generator and then runs
// request/acknowledge memory cycles until done, stop, or an ack timeout.
module dma_seq #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] cfg_mode,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_count,
  output logic [2:0] instr,
  output logic [7:0] am_din,
  output logic       cina,
  output logic       cinw,
  input  logic       am_done,
  output logic       xfer_req,
  input  logic       xfer_ack,
  output logic       busy,
  output logic       finished,
  output logic       err,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_LDCR, S_LDAR, S_LDWR, S_REINIT, S_REQ, S_STEP, S_FIN, S_ERR
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  logic [2:0] mode_q, mode_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] count_q, count_d;
  logic [7:0] wait_q, wait_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      wait_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    addr_d   = addr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    last_d   = last_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    instr    = 3'b011;
    am_din   = 8'h00;
    xfer_req = 1'b0;
    finished = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = cfg_mode;
          addr_d  = cfg_addr;
          count_d = cfg_count;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LDCR;
        end
      end
      S_LDCR: begin
        instr   = 3'b000;
        am_din  = {5'b0, mode_q};
        state_d = S_LDAR;
      end
      S_LDAR: begin
        instr   = 3'b101;
        am_din  = addr_q;
        state_d = S_LDWR;
      end
      S_LDWR: begin
        instr   = 3'b110;
        am_din  = count_q;
        state_d = S_REINIT;
      end
      S_REINIT: begin
        instr   = 3'b100;
        wait_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        xfer_req = 1'b1;
        // ack wins over both stop and timeout in the same cycle
        if (xfer_ack) begin
          last_d  = am_done | stop;
          state_d = S_STEP;
        end else if (stop) begin
          state_d = S_FIN;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_STEP: begin
        instr = 3'b111;
        cnt_d = cnt_q + 8'd1;
        if (last_q) begin
          state_d = S_FIN;
        end else begin
          wait_d  = '0;
          state_d = S_REQ;
        end
      end
      S_FIN: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign xfer_cnt = cnt_q;
  assign cina     = 1'b0;
  assign cinw     = 1'b0;

endmodule

// File: tb/tb_dma_seq.sv
// Directed bench for dma_seq with a minimal AM2940 address/word-count model.
module tb_dma_seq;

  logic       clk = 1'b0;
  logic       reset_n, start, stop, xfer_ack;
  logic [2:0] cfg_mode;
  logic [7:0] cfg_addr, cfg_count;
  logic [2:0] instr;
  logic [7:0] am_din, xfer_cnt;
  logic       cina, cinw, am_done, xfer_req, busy, finished, err;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_addr = '0;
  logic [7:0] m_wc   = '0;
  logic [2:0] m_mode = '0;

  dma_seq #(.MAX_WAIT(15)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_addr(cfg_addr), .cfg_count(cfg_count),
    .instr(instr), .am_din(am_din), .cina(cina), .cinw(cinw),
    .am_done(am_done), .xfer_req(xfer_req), .xfer_ack(xfer_ack),
    .busy(busy), .finished(finished), .err(err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  // AM2940 stand-in: address and word count registers driven by instr
  always @(posedge clk) begin
    case (instr)
      3'b000: m_mode <= am_din[2:0];
      3'b101: m_addr <= am_din;
      3'b110: m_wc   <= am_din;
      3'b111: begin m_addr <= m_addr + 8'd1; m_wc <= m_wc - 8'd1; end
      default: ;
    endcase
  end
  assign am_done = (m_mode[1:0] != 2'b11) && (m_wc == 8'd1);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pulse start in IDLE and advance to the first REQ cycle
  task automatic go(input logic [2:0] m, input logic [7:0] a, input logic [7:0] c);
    cfg_mode = m; cfg_addr = a; cfg_count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; xfer_ack = 1'b0;
    cfg_mode = '0; cfg_addr = '0; cfg_count = '0;
    repeat (2) tick();
    chk("rst_instr", instr, 3'b011);
    chk("rst_din", am_din, 8'h00);
    chk("rst_req", xfer_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fin", finished, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", xfer_cnt, 8'd0);
    chk("cin", {cina, cinw}, 2'b00);
    reset_n = 1'b1;
    tick();

    // basic three-word transfer
    cfg_mode = 3'b000; cfg_addr = 8'h10; cfg_count = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ldcr_instr", instr, 3'b000);
    chk("ldcr_din", am_din, 8'h00);
    chk("ldcr_busy", busy, 1'b1);
    tick();
    chk("ldar_instr", instr, 3'b101);
    chk("ldar_din", am_din, 8'h10);
    tick();
    chk("ldwr_instr", instr, 3'b110);
    chk("ldwr_din", am_din, 8'h03);
    tick();
    chk("reinit_instr", instr, 3'b100);
    chk("reinit_req", xfer_req, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t1_req", xfer_req, 1'b1);
      chk("t1_req_instr", instr, 3'b011);
      xfer_ack = 1'b1;
      tick();
      xfer_ack = 1'b0;
      chk("t1_step_instr", instr, 3'b111);
      chk("t1_step_req", xfer_req, 1'b0);
      tick();
    end
    chk("t1_fin", finished, 1'b1);
    chk("t1_cnt", xfer_cnt, 8'd3);
    tick();
    chk("t1_fin_once", finished, 1'b0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_am_addr", m_addr, 8'h13);

    // ack after four waiting cycles
    go(3'b000, 8'h40, 8'd1);
    n = 0;
    while (xfer_req && n < 40) begin
      xfer_ack = (n == 4);
      n++;
      tick();
    end
    xfer_ack = 1'b0;
    chk("t2_req_cycles", n, 5);
    chk("t2_step", instr, 3'b111);
    tick();
    chk("t2_fin", finished, 1'b1);
    chk("t2_err", err, 1'b0);
    chk("t2_cnt", xfer_cnt, 8'd1);
    tick();

    // no ack: timeout into ERR
    go(3'b000, 8'h00, 8'd4);
    n = 0;
    while (xfer_req && n < 40) begin
      n++;
      tick();
    end
    chk("t3_req_cycles", n, 15);
    chk("t3_err", err, 1'b1);
    chk("t3_err_fin", finished, 1'b0);
    tick();
    chk("t3_idle", busy, 1'b0);
    chk("t3_idle_fin", finished, 1'b0);
    repeat (3) tick();
    chk("t3_sticky", err, 1'b1);
    cfg_count = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_err_clr", err, 1'b0);

    // reset during REQ after one step
    repeat (4) tick();
    xfer_ack = 1'b1;
    tick();
    xfer_ack = 1'b0;
    tick();
    chk("t4_cnt_pre", xfer_cnt, 8'd1);
    chk("t4_in_req", xfer_req, 1'b1);
    reset_n = 1'b0;
    xfer_ack = 1'b1;
    tick();
    reset_n = 1'b1;
    xfer_ack = 1'b0;
    chk("t4_instr", instr, 3'b011);
    chk("t4_req", xfer_req, 1'b0);
    chk("t4_cnt", xfer_cnt, 8'd0);
    chk("t4_busy", busy, 1'b0);
    tick();
    chk("t4_stays_idle", busy, 1'b0);

    // mode 11: stop terminates without a step
    go(3'b011, 8'h80, 8'd5);
    xfer_ack = 1'b1;
    tick();
    xfer_ack = 1'b0;
    tick();
    chk("t5_req2", xfer_req, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t5_fin", finished, 1'b1);
    chk("t5_fin_instr", instr, 3'b011);
    chk("t5_cnt", xfer_cnt, 8'd1);
    chk("t5_am_addr", m_addr, 8'h81);
    tick();
    chk("t5_idle", busy, 1'b0);

    // start/cfg/stop activity while busy is ignored
    cfg_mode = 3'b000; cfg_addr = 8'h20; cfg_count = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; cfg_addr = 8'h55; cfg_count = 8'd9; stop = 1'b1;
    chk("t6_ldar_din", am_din, 8'h20);
    tick();
    start = 1'b0; stop = 1'b0;
    chk("t6_ldwr_din", am_din, 8'h02);
    tick();
    tick();
    chk("t6_req", xfer_req, 1'b1);
    start = 1'b1; xfer_ack = 1'b1;
    tick();
    start = 1'b0; xfer_ack = 1'b0; stop = 1'b1;
    chk("t6_step", instr, 3'b111);
    tick();
    stop = 1'b0;
    chk("t6_req2", xfer_req, 1'b1);
    xfer_ack = 1'b1;
    tick();
    xfer_ack = 1'b0;
    tick();
    chk("t6_fin", finished, 1'b1);
    chk("t6_cnt", xfer_cnt, 8'd2);
    tick();
    chk("t6_idle", busy, 1'b0);
    chk("t6_am_addr", m_addr, 8'h22);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
